gb_oam_dma: RTL and testbench

// - Internal OAM DMA controller for register FF46: copies LENGTH bytes from {src,8'h00} into OAM.
// - Owns the external source bus during transfer: drives adr_dma/rd_dma in place of the external DMA pins.
// - Writes OAM through oam_adr/oam_dout/oam_write; dma_active gates CPU access to ext bus and video in top.
// - Runs on gbclk; one M-cycle = 4 clocks, one byte per M-cycle.

---
 rtl/gb_oam_dma.sv | 134 +++++++++++++
 tb/tb_gb_oam_dma.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_oam_dma.sv
// OAM DMA engine behind register FF46: copies LENGTH bytes from {src,8'h00} into OAM,
// one byte per 4-clock M-cycle, owning the external source bus while it runs.
module gb_oam_dma #(
  parameter int LENGTH      = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        write_reg,
  input  logic        read,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  bus_din,
  output logic [15:0] adr_dma,
  output logic        rd_dma,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        dma_active,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int            DW       = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [DW-1:0] DLY_INIT = DW'(START_DELAY);
  localparam logic [DW-1:0] DLY_ONE  = DW'(1);
  localparam logic [7:0]    LAST_IDX = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [1:0]      phase_q, phase_n;
  logic [DW-1:0]   dcnt_q, dcnt_n;
  logic [7:0]      idx_q, idx_n;
  logic [7:0]      src_q, src_n;
  logic [7:0]      src_eff_n;
  logic            boundary;
  logic            xfer_n;
  logic            wr_n;

  // Strobe semantics: rd_dma marks adr_dma as a valid source read in phases 0-2
  // (bus_din sampled on the edge ending phase 2); oam_write is a one-clock strobe
  // qualifying oam_adr/oam_dout, with no back-pressure on either side.

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      dcnt_q  <= '0;
      idx_q   <= 8'h00;
      src_q   <= 8'h00;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      dcnt_q  <= dcnt_n;
      idx_q   <= idx_n;
      src_q   <= src_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    dcnt_n   = dcnt_q;
    idx_n    = idx_q;
    src_n    = src_q;
    phase_n  = phase_q + 2'd1;
    boundary = (phase_q == 2'd3);
    if (write_reg) begin
      // A register write always wins, including over the final byte's phase-3 edge.
      src_n   = din;
      dcnt_n  = DLY_INIT;
      idx_n   = 8'h00;
      state_n = S_DELAY;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (boundary) begin
            if (dcnt_q == DLY_ONE) state_n = S_XFER;
            else                   dcnt_n  = dcnt_q - DLY_ONE;
          end
        end
        S_XFER: begin
          if (boundary) begin
            if (idx_q == LAST_IDX) begin
              state_n = S_IDLE;
              idx_n   = 8'h00;
            end else begin
              idx_n = idx_q + 8'h01;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Echo RAM sources E0-FF alias onto C0-DF.
  always_comb begin
    src_eff_n = src_n;
    if (src_n[7:5] == 3'b111) src_eff_n = {src_n[7:6], 1'b0, src_n[4:0]};
  end

  assign xfer_n = (state_n == S_XFER);
  assign wr_n   = xfer_n && (phase_n == 2'd3);

  // Outputs are decoded from next state so every one is a clean flop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      adr_dma    <= 16'h0000;
      rd_dma     <= 1'b0;
      oam_adr    <= 8'h00;
      oam_dout   <= 8'h00;
      oam_write  <= 1'b0;
      dma_active <= 1'b0;
      busy       <= 1'b0;
    end else begin
      adr_dma    <= xfer_n ? {src_eff_n, idx_n} : 16'h0000;
      rd_dma     <= xfer_n && (phase_n != 2'd3);
      oam_write  <= wr_n;
      oam_adr    <= wr_n ? idx_n : 8'h00;
      oam_dout   <= wr_n ? bus_din : 8'h00;
      dma_active <= xfer_n;
      busy       <= (state_n != S_IDLE);
    end
  end

  assign dout      = read ? src_q : 8'h00;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Scoreboard bench for gb_oam_dma: default-length instance plus a LENGTH=256 instance,
// with a bus model returning adr[7:0]^8'h5A.
module tb_gb_oam_dma;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        write_reg = 1'b0;
  logic        write_reg2 = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  din = 8'h00;

  logic [7:0]  dout, bus_din, oam_adr, oam_dout;
  logic [15:0] adr_dma;
  logic        rd_dma, oam_write, dma_active, busy;
  logic [1:0]  dbg_state;

  logic [7:0]  dout2, bus_din2, oam_adr2, oam_dout2;
  logic [15:0] adr_dma2;
  logic        rd_dma2, oam_write2, dma_active2, busy2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  int act_cnt = 0;
  int act2_cnt = 0;
  logic [7:0] last_adr2 = 8'h00;
  logic [1:0] tb_phase;

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) tb_phase <= 2'd0;
    else          tb_phase <= tb_phase + 2'd1;
  end

  assign bus_din  = adr_dma[7:0] ^ 8'h5A;
  assign bus_din2 = adr_dma2[7:0] ^ 8'h5A;

  gb_oam_dma u_dut (
    .clk(clk), .n_reset(n_reset), .write_reg(write_reg), .read(read), .din(din),
    .dout(dout), .bus_din(bus_din), .adr_dma(adr_dma), .rd_dma(rd_dma),
    .oam_adr(oam_adr), .oam_dout(oam_dout), .oam_write(oam_write),
    .dma_active(dma_active), .busy(busy), .dbg_state(dbg_state)
  );

  gb_oam_dma #(.LENGTH(256), .START_DELAY(1)) u_dut256 (
    .clk(clk), .n_reset(n_reset), .write_reg(write_reg2), .read(read), .din(din),
    .dout(dout2), .bus_din(bus_din2), .adr_dma(adr_dma2), .rd_dma(rd_dma2),
    .oam_adr(oam_adr2), .oam_dout(oam_dout2), .oam_write(oam_write2),
    .dma_active(dma_active2), .busy(busy2), .dbg_state(dbg_state2)
  );

  // scoreboard monitors: pop one expected {adr_dma, oam_adr, oam_dout} per OAM write
  always @(negedge clk) begin
    logic [31:0] e;
    if (dma_active) act_cnt++;
    if (oam_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_oam_write got adr=%h oam_adr=%h data=%h", adr_dma, oam_adr, oam_dout);
      end else begin
        e = exp_q.pop_front();
        if ({adr_dma, oam_adr, oam_dout} !== e) begin
          failures++;
          $display("FAIL oam_write got=%h exp=%h", {adr_dma, oam_adr, oam_dout}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (dma_active2) act2_cnt++;
    if (oam_write2) begin
      checks++;
      last_adr2 = oam_adr2;
      if (exp2_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_oam_write_256 got adr=%h oam_adr=%h data=%h", adr_dma2, oam_adr2, oam_dout2);
      end else begin
        e = exp2_q.pop_front();
        if ({adr_dma2, oam_adr2, oam_dout2} !== e) begin
          failures++;
          $display("FAIL oam_write_256 got=%h exp=%h", {adr_dma2, oam_adr2, oam_dout2}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d, input logic [1:0] p, input bit sel);
    int n = 0;
    while (tb_phase != p && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    din = d;
    if (sel) write_reg2 = 1'b1;
    else     write_reg  = 1'b1;
    @(posedge clk); #1;
    write_reg  = 1'b0;
    write_reg2 = 1'b0;
  endtask

  task automatic push_seq(input logic [7:0] eff, input int first, input int last, input bit sel);
    logic [7:0] i8;
    for (int i = first; i <= last; i++) begin
      i8 = 8'(i);
      if (sel) exp2_q.push_back({eff, i8, i8, i8 ^ 8'h5A});
      else     exp_q.push_back({eff, i8, i8, i8 ^ 8'h5A});
    end
  endtask

  task automatic wait_first_rd(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rd_dma) break;
    end
  endtask

  task automatic wait_rd_byte(input logic [7:0] b);
    int n = 0;
    while (!(rd_dma && adr_dma[7:0] == b) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_rd_byte_timeout", 32'(n), 0);
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    @(negedge clk);
    while ((sel ? busy2 : busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("wait_idle_timeout", 32'(n), 0);
  endtask

  initial begin
    int lat;
    int s;

    // reset state
    repeat (3) @(negedge clk);
    read = 1'b1;
    chk("reset_outputs", {busy, dma_active, rd_dma, oam_write, dbg_state}, 0);
    chk("reset_buses", {adr_dma, oam_adr, oam_dout}, 0);
    chk("reset_dout", 32'(dout), 32'h00);
    read = 1'b0;
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // C1 written at phase 1: one boundary of delay, 160 bytes from C100
    s = act_cnt;
    push_seq(8'hC1, 0, 159, 1'b0);
    do_write(8'hC1, 2'd1, 1'b0);
    chk("c1_busy_next_clk", {31'd0, busy}, 1);
    wait_first_rd(lat);
    chk("c1_first_rd_latency", 32'(lat), 3);
    chk("c1_first_adr", 32'(adr_dma), 32'hC100);
    read = 1'b1;
    #1 chk("c1_dout", 32'(dout), 32'hC1);
    read = 1'b0;
    wait_idle(1'b0);
    chk("c1_active_clocks", 32'(act_cnt - s), 640);
    chk("c1_queue_empty", 32'(exp_q.size()), 0);

    // FE aliases to DE; dout keeps the raw value
    s = act_cnt;
    push_seq(8'hDE, 0, 159, 1'b0);
    do_write(8'hFE, 2'd3, 1'b0);
    wait_first_rd(lat);
    chk("fe_first_rd_latency", 32'(lat), 5);
    chk("fe_first_adr", 32'(adr_dma), 32'hDE00);
    read = 1'b1;
    #1 chk("fe_dout", 32'(dout), 32'hFE);
    read = 1'b0;
    wait_idle(1'b0);
    chk("fe_active_clocks", 32'(act_cnt - s), 640);
    chk("fe_queue_empty", 32'(exp_q.size()), 0);

    // restart with 80 during byte 50 phase 1
    s = act_cnt;
    push_seq(8'h12, 0, 49, 1'b0);
    do_write(8'h12, 2'd0, 1'b0);
    wait_rd_byte(8'd50);
    do_write(8'h80, 2'd1, 1'b0);
    chk("restart_active_drop", {30'd0, dma_active, busy}, 1);
    chk("restart_rd_drop", {31'd0, rd_dma}, 0);
    push_seq(8'h80, 0, 159, 1'b0);
    wait_idle(1'b0);
    chk("restart_active_clocks", 32'(act_cnt - s), 202 + 640);
    chk("restart_queue_empty", 32'(exp_q.size()), 0);

    // rewrite during DELAY: only 44 is transferred, delay restarts
    s = act_cnt;
    push_seq(8'h44, 0, 159, 1'b0);
    do_write(8'h33, 2'd2, 1'b0);
    chk("delay_state", 32'(dbg_state), 1);
    do_write(8'h44, 2'd3, 1'b0);
    wait_first_rd(lat);
    chk("delay_restart_latency", 32'(lat), 5);
    chk("delay_restart_adr", 32'(adr_dma), 32'h4400);
    wait_idle(1'b0);
    chk("delay_active_clocks", 32'(act_cnt - s), 640);
    chk("delay_queue_empty", 32'(exp_q.size()), 0);

    // write in the same clock as the final oam_write
    push_seq(8'h55, 0, 159, 1'b0);
    do_write(8'h55, 2'd0, 1'b0);
    wait_rd_byte(8'd159);
    do_write(8'h66, 2'd3, 1'b0);
    chk("final_write_restart_state", {29'd0, busy, dbg_state}, {29'd0, 1'b1, 2'd1});
    push_seq(8'h66, 0, 159, 1'b0);
    wait_idle(1'b0);
    chk("final_write_queue_empty", 32'(exp_q.size()), 0);

    // reset mid-transfer at byte 10
    push_seq(8'h21, 0, 9, 1'b0);
    do_write(8'h21, 2'd0, 1'b0);
    wait_rd_byte(8'd10);
    read = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    chk("midreset_outputs", {busy, dma_active, rd_dma, oam_write}, 0);
    chk("midreset_buses", {adr_dma, oam_adr, oam_dout}, 0);
    chk("midreset_dout", 32'(dout), 32'h00);
    read = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_state_idle", {29'd0, busy, dbg_state}, 0);
    repeat (40) @(negedge clk);
    chk("midreset_queue_empty", 32'(exp_q.size()), 0);

    // LENGTH=256 instance: idx 0..FF, then idle, no 257th write
    s = act2_cnt;
    push_seq(8'h3C, 0, 255, 1'b1);
    do_write(8'h3C, 2'd2, 1'b1);
    wait_idle(1'b1);
    repeat (20) @(negedge clk);
    chk("len256_queue_empty", 32'(exp2_q.size()), 0);
    chk("len256_last_adr", 32'(last_adr2), 32'hFF);
    chk("len256_active_clocks", 32'(act2_cnt - s), 1024);
    chk("len256_state_idle", {29'd0, busy2, dbg_state2}, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
